// File: rtl/heart_life_ctrl.sv
// -----------------------------------------------------------------------------
// heart_life_ctrl
// Player health controller. It owns the heart count shown by the HUD and
// applies damage and heal requests. After a hit it opens an invincibility
// window, counted in video frames, and blinks the player sprite while that
// window is open. It raises game-over when the last heart is lost.
//
// Parameters:
//   MAX_HEART  - hearts after reset/restart (1..3)
//   INV_FRAMES - invincibility window length in frame ticks (1..255)
//   BLINK_HALF - frame ticks per blink half-period (1..255)
//
// Ports:
//   clk        in   system (pixel) clock, rising edge
//   reset      in   synchronous active-high reset
//   frame_tick in   one-cycle pulse per video frame
//   hit        in   damage request (level, sampled every cycle)
//   heal       in   +1 heart request (level, sampled every cycle)
//   restart    in   return to full health from any state
//   num_heart  out  registered heart count (0..3)
//   hit_ack    out  one-cycle pulse when a hit is applied
//   invincible out  high while the invincibility window is open
//   blink_off  out  sprite hide flag, only ever high while invincible
//   game_over  out  high once all hearts are lost
// -----------------------------------------------------------------------------
module heart_life_ctrl #(
  parameter int MAX_HEART  = 3,
  parameter int INV_FRAMES = 90,
  parameter int BLINK_HALF = 6
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       frame_tick,
  input  logic       hit,
  input  logic       heal,
  input  logic       restart,
  output logic [1:0] num_heart,
  output logic       hit_ack,
  output logic       invincible,
  output logic       blink_off,
  output logic       game_over
);

  localparam logic [1:0] MAX_H      = 2'(MAX_HEART);
  localparam logic [7:0] INV_LOAD   = 8'(INV_FRAMES);
  localparam logic [7:0] BLINK_LAST = 8'(BLINK_HALF - 1);

  typedef enum logic [1:0] {
    ST_ALIVE = 2'd0,
    ST_INV   = 2'd1,
    ST_DEAD  = 2'd2
  } state_t;

  state_t     state_r, state_s;
  logic [1:0] heart_r, heart_s;
  logic [7:0] inv_cnt_r, inv_cnt_s;
  logic [7:0] blink_cnt_r, blink_cnt_s;
  logic       blink_off_r, blink_off_s;
  logic       hit_ack_r, hit_ack_s;
  logic       invincible_r, invincible_s;
  logic       game_over_r, game_over_s;
  logic [1:0] heal_sat_s;

  // Saturating +1 used by both ALIVE and INVINCIBLE heal paths.
  always_comb begin
    if (heart_r < MAX_H) begin
      heal_sat_s = heart_r + 2'd1;
    end else begin
      heal_sat_s = heart_r;
    end
  end

  // State register plus all registered datapath values and outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r      <= ST_ALIVE;
      heart_r      <= MAX_H;
      inv_cnt_r    <= 8'd0;
      blink_cnt_r  <= 8'd0;
      blink_off_r  <= 1'b0;
      hit_ack_r    <= 1'b0;
      invincible_r <= 1'b0;
      game_over_r  <= 1'b0;
    end else begin
      state_r      <= state_s;
      heart_r      <= heart_s;
      inv_cnt_r    <= inv_cnt_s;
      blink_cnt_r  <= blink_cnt_s;
      blink_off_r  <= blink_off_s;
      hit_ack_r    <= hit_ack_s;
      invincible_r <= invincible_s;
      game_over_r  <= game_over_s;
    end
  end

  // Next-state logic; restart overrides every other request.
  always_comb begin
    state_s = state_r;
    if (restart) begin
      state_s = ST_ALIVE;
    end else begin
      case (state_r)
        ST_ALIVE: begin
          if (hit) begin
            if (heart_r > 2'd1) begin
              state_s = ST_INV;
            end else begin
              state_s = ST_DEAD;
            end
          end else begin
            state_s = ST_ALIVE;
          end
        end
        ST_INV: begin
          // The tick that consumes the last window frame closes the window.
          if (frame_tick && (inv_cnt_r == 8'd1)) begin
            state_s = ST_ALIVE;
          end else begin
            state_s = ST_INV;
          end
        end
        ST_DEAD: begin
          state_s = ST_DEAD;
        end
        default: begin
          state_s = ST_ALIVE;
        end
      endcase
    end
  end

  // Next values for hearts, counters and flag outputs.
  always_comb begin
    heart_s     = heart_r;
    inv_cnt_s   = inv_cnt_r;
    blink_cnt_s = blink_cnt_r;
    blink_off_s = blink_off_r;
    hit_ack_s   = 1'b0;
    if (restart) begin
      heart_s     = MAX_H;
      inv_cnt_s   = 8'd0;
      blink_cnt_s = 8'd0;
      blink_off_s = 1'b0;
    end else begin
      case (state_r)
        ST_ALIVE: begin
          if (hit) begin
            // Hit wins over a same-cycle heal; the heal is simply dropped.
            hit_ack_s   = 1'b1;
            blink_cnt_s = 8'd0;
            blink_off_s = 1'b0;
            if (heart_r > 2'd1) begin
              heart_s   = heart_r - 2'd1;
              inv_cnt_s = INV_LOAD;
            end else begin
              heart_s   = 2'd0;
              inv_cnt_s = 8'd0;
            end
          end else if (heal) begin
            heart_s = heal_sat_s;
          end else begin
            heart_s = heart_r;
          end
        end
        ST_INV: begin
          if (heal) begin
            heart_s = heal_sat_s;
          end else begin
            heart_s = heart_r;
          end
          if (frame_tick) begin
            inv_cnt_s = inv_cnt_r - 8'd1;
            if (inv_cnt_r == 8'd1) begin
              // Leaving the window: sprite must be visible again.
              blink_cnt_s = 8'd0;
              blink_off_s = 1'b0;
            end else if (blink_cnt_r >= BLINK_LAST) begin
              blink_cnt_s = 8'd0;
              blink_off_s = ~blink_off_r;
            end else begin
              blink_cnt_s = blink_cnt_r + 8'd1;
            end
          end else begin
            inv_cnt_s = inv_cnt_r;
          end
        end
        ST_DEAD: begin
          heart_s = heart_r;
        end
        default: begin
          heart_s     = MAX_H;
          inv_cnt_s   = 8'd0;
          blink_cnt_s = 8'd0;
          blink_off_s = 1'b0;
        end
      endcase
    end
  end

  // Mode flags follow the state being entered so they register with it.
  always_comb begin
    invincible_s = (state_s == ST_INV);
    game_over_s  = (state_s == ST_DEAD);
  end

  assign num_heart  = heart_r;
  assign hit_ack    = hit_ack_r;
  assign invincible = invincible_r;
  assign blink_off  = blink_off_r;
  assign game_over  = game_over_r;

endmodule

// File: tb/tb_heart_life_ctrl.sv
// -----------------------------------------------------------------------------
// tb_heart_life_ctrl
// Self-checking bench for heart_life_ctrl (MAX_HEART=3, INV_FRAMES=4,
// BLINK_HALF=2). A behavioural model tracks hearts, the current mode and the
// number of frame ticks since the window opened; the blink flag is derived
// from that tick count. Directed scenarios are followed by random stimulus.
// -----------------------------------------------------------------------------
module tb_heart_life_ctrl;

  localparam int MAXH = 3;
  localparam int INVF = 4;
  localparam int BLH  = 2;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       frame_tick = 1'b0;
  logic       hit = 1'b0;
  logic       heal = 1'b0;
  logic       restart = 1'b0;
  logic [1:0] num_heart;
  logic       hit_ack;
  logic       invincible;
  logic       blink_off;
  logic       game_over;

  heart_life_ctrl #(
    .MAX_HEART (MAXH),
    .INV_FRAMES(INVF),
    .BLINK_HALF(BLH)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .frame_tick(frame_tick),
    .hit       (hit),
    .heal      (heal),
    .restart   (restart),
    .num_heart (num_heart),
    .hit_ack   (hit_ack),
    .invincible(invincible),
    .blink_off (blink_off),
    .game_over (game_over)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Model: mode 0=alive, 1=invincible, 2=dead.
  int m_hearts = MAXH;
  int m_mode   = 0;
  int m_ticks  = 0;
  int m_ack    = 0;

  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_update();
    if (reset || restart) begin
      m_hearts = MAXH;
      m_mode   = 0;
      m_ticks  = 0;
      m_ack    = 0;
    end else if (m_mode == 0) begin
      m_ack = 0;
      if (hit) begin
        m_ack    = 1;
        m_hearts = m_hearts - 1;
        m_ticks  = 0;
        m_mode   = (m_hearts == 0) ? 2 : 1;
      end else if (heal) begin
        m_hearts = (m_hearts + 1 > MAXH) ? MAXH : m_hearts + 1;
      end
    end else if (m_mode == 1) begin
      m_ack = 0;
      if (heal) m_hearts = (m_hearts + 1 > MAXH) ? MAXH : m_hearts + 1;
      if (frame_tick) begin
        m_ticks++;
        if (m_ticks == INVF) m_mode = 0;
      end
    end else begin
      m_ack = 0;
    end
  endtask

  // Apply one cycle of inputs, advance the model, check every output.
  task automatic step(input logic r, input logic rs, input logic t,
                      input logic h, input logic he);
    int exp_blink;
    reset = r; restart = rs; frame_tick = t; hit = h; heal = he;
    @(posedge clk);
    model_update();
    #1;
    exp_blink = (m_mode == 1) ? ((m_ticks / BLH) % 2) : 0;
    chk("num_heart",  int'(num_heart),  m_hearts);
    chk("hit_ack",    int'(hit_ack),    m_ack);
    chk("invincible", int'(invincible), (m_mode == 1) ? 1 : 0);
    chk("game_over",  int'(game_over),  (m_mode == 2) ? 1 : 0);
    chk("blink_off",  int'(blink_off),  exp_blink);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    end
  endtask

  initial begin
    int acks;
    // Reset
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("rst_heart", int'(num_heart), 3);
    chk("rst_flags", int'({hit_ack, invincible, blink_off, game_over}), 0);
    idle(1);

    // Single hit, full window with blink toggles after ticks 2 and 4
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("hit1_heart", int'(num_heart), 2);
    chk("hit1_ack", int'(hit_ack), 1);
    chk("hit1_inv", int'(invincible), 1);
    idle(1);
    chk("hit1_ack_drop", int'(hit_ack), 0);
    ticks(2);
    chk("blink_after2", int'(blink_off), 1);
    ticks(1);
    chk("inv_after3", int'(invincible), 1);
    ticks(1);
    chk("inv_after4", int'(invincible), 0);

    // Held hit: one ack only
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    acks = 0;
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      acks += int'(hit_ack);
    end
    chk("held_acks", acks, 1);
    chk("held_heart", int'(num_heart), 2);

    // Three separated hits to game over
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0); ticks(INVF);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0); ticks(INVF);
    chk("two_hits_heart", int'(num_heart), 1);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("dead_heart", int'(num_heart), 0);
    chk("dead_go", int'(game_over), 1);
    chk("dead_inv", int'(invincible), 0);
    step(1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("dead_stays", int'(num_heart), 0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("restart_heart", int'(num_heart), 3);
    chk("restart_go", int'(game_over), 0);

    // Hit and heal together at full hearts
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    chk("hitheal_heart", int'(num_heart), 2);
    // Heal during the window
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("invheal_heart", int'(num_heart), 3);
    chk("invheal_inv", int'(invincible), 1);
    // Extra heal saturates
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("heal_sat", int'(num_heart), 3);

    // Restart while the sprite is hidden
    ticks(2);
    chk("pre_restart_blink", int'(blink_off), 1);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("rs_inv", int'(invincible), 0);
    chk("rs_blink", int'(blink_off), 0);
    chk("rs_heart", int'(num_heart), 3);

    // Hit coinciding with a tick: tick does not count toward the window
    step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    ticks(INVF - 1);
    chk("hit_tick_inv", int'(invincible), 1);
    ticks(1);
    chk("hit_tick_done", int'(invincible), 0);

    // Random stimulus
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 599) == 0),
           ($urandom_range(0, 199) == 0),
           ($urandom_range(0, 2) == 0),
           ($urandom_range(0, 7) == 0),
           ($urandom_range(0, 9) == 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
